branch_redirect_ctrl: RTL and testbench

- Sequences branch resolution for the pipelined RV32I core. It sits between the execute stage and fetch.
- Each cycle it takes the comparator's branch_taken result and checks it against the fetch-time prediction.
- On a mispredict it issues a PC redirect to fetch over a valid/ready handshake, then flushes the younger pipeline stages for a fixed number of cycles.
- It also keeps saturating branch and mispredict counters for performance monitoring.

---
 rtl/branch_redirect_ctrl.sv | 152 +++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Branch resolution and fetch redirect sequencer for the RV32I pipeline.
// Detects mispredicts in execute, hands a corrected PC to fetch, then flushes younger stages.
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic             branch_taken,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic             redirect_ready,
  input  logic             stats_clr,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             stall_ex,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  // Handshake: a redirect transfers on any rising edge where redirect_valid and
  // redirect_ready are both high; until then redirect_valid and redirect_pc hold.

  state_e             state_q, state_d;
  logic [3:0]         flush_cnt_q, flush_cnt_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]   misp_cnt_q, misp_cnt_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic               flush_q, flush_d;
  logic               stall_q, stall_d;

  logic               resolve;
  logic               actual;
  logic               mispredict;
  logic [31:0]        correct_pc;

  always_comb begin
    resolve    = 1'b0;
    actual     = 1'b0;
    mispredict = 1'b0;
    correct_pc = 32'd0;
    resolve    = (state_q == IDLE) && ex_valid && (ex_branch || ex_jump);
    actual     = ex_jump | branch_taken;
    mispredict = actual ^ ex_pred_taken;
    correct_pc = actual ? (ex_pc + ex_imm) : (ex_pc + 32'd4);
  end

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (resolve && mispredict) begin
          redirect_pc_d = correct_pc;
          state_d       = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          flush_cnt_d = FLUSH_LOAD;
          state_d     = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pipeline control flags are registered copies decoded from the next state.
  always_comb begin
    redirect_valid_d = 1'b0;
    flush_d          = 1'b0;
    stall_d          = 1'b0;
    redirect_valid_d = (state_d == REDIRECT);
    stall_d          = (state_d == REDIRECT);
    flush_d          = (state_d == REDIRECT) || (state_d == FLUSH);
  end

  // Clear beats a same-cycle increment; both counters stick at all-ones.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    misp_cnt_d   = misp_cnt_q;
    if (stats_clr) begin
      branch_cnt_d = '0;
      misp_cnt_d   = '0;
    end else begin
      if (resolve && (branch_cnt_q != '1)) begin
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
      if (resolve && mispredict && (misp_cnt_q != '1)) begin
        misp_cnt_d = misp_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      flush_cnt_q      <= 4'd0;
      redirect_pc_q    <= 32'd0;
      branch_cnt_q     <= '0;
      misp_cnt_q       <= '0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      misp_cnt_q       <= misp_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      stall_q          <= stall_d;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign flush_if_id      = flush_q;
  assign flush_id_ex      = flush_q;
  assign stall_ex         = stall_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = misp_cnt_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: redirect handshake, flush length,
// wrap-around target, squashed resolves, counter saturation and clear.
module tb_branch_redirect_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid, ex_branch, ex_jump, branch_taken, ex_pred_taken;
  logic [31:0]      ex_pc, ex_imm;
  logic             redirect_ready, stats_clr;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_if_id, flush_id_ex, stall_ex;
  logic [CNT_W-1:0] branch_count, mispredict_count;
  logic [1:0]       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk = ~clk;

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid         (ex_valid),
    .ex_branch        (ex_branch),
    .ex_jump          (ex_jump),
    .branch_taken     (branch_taken),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pc            (ex_pc),
    .ex_imm           (ex_imm),
    .redirect_ready   (redirect_ready),
    .stats_clr        (stats_clr),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .stall_ex         (stall_ex),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count),
    .dbg_state        (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic br, input logic jmp, input logic tkn, input logic pred,
                          input logic [31:0] pc, input logic [31:0] imm);
    ex_valid      = 1'b1;
    ex_branch     = br;
    ex_jump       = jmp;
    branch_taken  = tkn;
    ex_pred_taken = pred;
    ex_pc         = pc;
    ex_imm        = imm;
  endtask

  task automatic idle_ex();
    ex_valid      = 1'b0;
    ex_branch     = 1'b0;
    ex_jump       = 1'b0;
    branch_taken  = 1'b0;
    ex_pred_taken = 1'b0;
    ex_pc         = 32'd0;
    ex_imm        = 32'd0;
  endtask

  task automatic check_ctl(input string tag, input logic rv, input logic fl, input logic st);
    check({tag, "_rv"},    {63'd0, redirect_valid}, {63'd0, rv});
    check({tag, "_fl_if"}, {63'd0, flush_if_id},    {63'd0, fl});
    check({tag, "_fl_ex"}, {63'd0, flush_id_ex},    {63'd0, fl});
    check({tag, "_stall"}, {63'd0, stall_ex},       {63'd0, st});
  endtask

  task automatic check_cnt(input string tag, input int bc, input int mc);
    check({tag, "_bc"}, 64'(branch_count),     64'(bc));
    check({tag, "_mc"}, 64'(mispredict_count), 64'(mc));
  endtask

  initial begin
    rst = 1'b1;
    redirect_ready = 1'b0;
    stats_clr = 1'b0;
    idle_ex();
    tick();
    tick();
    rst = 1'b0;

    check_ctl("reset", 1'b0, 1'b0, 1'b0);
    check("reset_pc", 64'(redirect_pc), 64'h0);
    check("reset_state", 64'(dbg_state), 64'd0);
    check_cnt("reset", 0, 0);

    // Reset while a redirect is waiting for fetch
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h8);
    tick();
    idle_ex();
    check_ctl("rstmid_redir", 1'b1, 1'b1, 1'b1);
    check("rstmid_pc", 64'(redirect_pc), 64'h308);
    tick();
    tick();
    check_ctl("rstmid_held", 1'b1, 1'b1, 1'b1);
    check_cnt("rstmid_pre", 1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_ctl("rstmid_after", 1'b0, 1'b0, 1'b0);
    check("rstmid_after_pc", 64'(redirect_pc), 64'h0);
    check("rstmid_after_state", 64'(dbg_state), 64'd0);
    check_cnt("rstmid_after", 0, 0);

    // BEQ predicted not-taken, actually taken; fetch ready immediately
    redirect_ready = 1'b1;
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h20);
    tick();
    idle_ex();
    check_ctl("beq_redir", 1'b1, 1'b1, 1'b1);
    check("beq_pc", 64'(redirect_pc), 64'h120);
    check_cnt("beq", 1, 1);
    tick();
    check_ctl("beq_flush1", 1'b0, 1'b1, 1'b0);
    tick();
    check_ctl("beq_flush2", 1'b0, 1'b1, 1'b0);
    tick();
    check_ctl("beq_idle", 1'b0, 1'b0, 1'b0);
    check("beq_idle_pc", 64'(redirect_pc), 64'h120);

    // BNE predicted taken, actually not-taken; fetch back-pressures 3 cycles
    redirect_ready = 1'b0;
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h40);
    tick();
    idle_ex();
    for (int i = 0; i < 3; i++) begin
      check_ctl($sformatf("bne_hold%0d", i), 1'b1, 1'b1, 1'b1);
      check($sformatf("bne_pc%0d", i), 64'(redirect_pc), 64'h204);
      if (i < 2) tick();
    end
    check_cnt("bne", 2, 2);
    redirect_ready = 1'b1;
    tick();
    check_ctl("bne_flush1", 1'b0, 1'b1, 1'b0);
    tick();
    check_ctl("bne_flush2", 1'b0, 1'b1, 1'b0);
    tick();
    check_ctl("bne_idle", 1'b0, 1'b0, 1'b0);

    // Correct predictions back-to-back; ready high in IDLE must do nothing
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check_cnt("clr", 0, 0);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive_ex(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h10);
        1: drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h404, 32'h10);
        2: drive_ex(1'b0, 1'b1, 1'b0, 1'b1, 32'h408, 32'h100);
        3: drive_ex(1'b1, 1'b0, 1'b1, 1'b1, 32'h508, 32'hFFFFFFF0);
        default: drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h4F8, 32'h8);
      endcase
      tick();
      check_ctl($sformatf("ok%0d", i), 1'b0, 1'b0, 1'b0);
    end
    check_cnt("ok", 5, 0);
    // Neither a non-branch nor an invalid branch is a resolve
    drive_ex(1'b0, 1'b0, 1'b1, 1'b0, 32'h600, 32'h4);
    tick();
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h604, 32'h4);
    ex_valid = 1'b0;
    tick();
    idle_ex();
    check_ctl("nonbr", 1'b0, 1'b0, 1'b0);
    check_cnt("nonbr", 5, 0);

    // JAL mispredicted with target wrapping past 2^32
    redirect_ready = 1'b0;
    drive_ex(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFF0, 32'h20);
    tick();
    check_ctl("jal_redir", 1'b1, 1'b1, 1'b1);
    check("jal_pc", 64'(redirect_pc), 64'h10);
    check_cnt("jal", 6, 1);
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h700, 32'h80);
    tick();
    check("jal_pc_hold", 64'(redirect_pc), 64'h10);
    check_cnt("jal_squash_redir", 6, 1);
    redirect_ready = 1'b1;
    tick();
    check_ctl("jal_flush1", 1'b0, 1'b1, 1'b0);
    tick();
    check_ctl("jal_flush2", 1'b0, 1'b1, 1'b0);
    tick();
    idle_ex();
    check_ctl("jal_idle", 1'b0, 1'b0, 1'b0);
    check("jal_idle_state", 64'(dbg_state), 64'd0);
    check("jal_idle_pc", 64'(redirect_pc), 64'h10);
    check_cnt("jal_squash", 6, 1);

    // Saturation of both counters at 15
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h40);
      tick();
      idle_ex();
      tick();
      tick();
      tick();
    end
    check_ctl("sat_idle", 1'b0, 1'b0, 1'b0);
    check_cnt("sat", 15, 15);

    // Clear wins over a same-cycle mispredicting resolve; redirect still issued
    stats_clr = 1'b1;
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h40);
    tick();
    stats_clr = 1'b0;
    idle_ex();
    check_cnt("clr_vs_inc", 0, 0);
    check_ctl("clr_redir", 1'b1, 1'b1, 1'b1);
    check("clr_pc", 64'(redirect_pc), 64'h2004);
    tick();
    tick();
    tick();
    check_ctl("final_idle", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
